serdesphy_rx_fifo_ctrl: RTL

Read-side controller for the RX elastic FIFO, running in the 24 MHz system clock domain. It sequences FIFO start-up: a prefill wait, then streaming drain into a registered valid/ready byte output, then error recovery. On a sticky overflow or underflow it pulses the FIFO reset and restarts. It also keeps saturating error counters for the CSR block.

---
 rtl/serdesphy_rx_fifo_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/serdesphy_rx_fifo_ctrl.sv
// Read-side controller for the RX elastic FIFO: prefill wait, paced drain into a
// registered valid/ready byte stage, and FIFO-reset recovery on sticky errors.
module serdesphy_rx_fifo_ctrl #(
  parameter int PREFILL_CYCLES = 4,
  parameter int RST_CYCLES     = 3,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [7:0]           fifo_rd_data,
  input  logic                 fifo_rd_valid,
  input  logic                 fifo_overflow,
  input  logic                 fifo_underflow,
  output logic                 fifo_rd_enable,
  output logic                 fifo_read,
  output logic                 fifo_rst_n,
  output logic [7:0]           out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [1:0]           state,
  output logic                 link_active,
  output logic [CNT_WIDTH-1:0] overflow_count,
  output logic [CNT_WIDTH-1:0] underflow_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PREFILL = 2'd1,
    STREAM  = 2'd2,
    RECOVER = 2'd3
  } state_t;

  localparam logic [3:0]           PF_LAST  = 4'(PREFILL_CYCLES - 1);
  localparam logic [3:0]           RST_LAST = 4'(RST_CYCLES - 1);
  localparam logic [3:0]           RST_END  = 4'(RST_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

  state_t     st;
  logic [3:0] pf_cnt;
  logic [3:0] rst_cnt;
  logic       pop_guard;
  logic       err;
  logic       active;
  logic       pop;

  // Handshake: out_data is held stable while out_valid is high; a byte is
  // transferred in any cycle where out_valid & out_ready are both high.
  assign state     = st;
  assign err       = fifo_overflow | fifo_underflow;
  assign active    = (st == PREFILL) || (st == STREAM);
  // The FIFO empty flag is registered, so the cycle after a pop is never trusted.
  assign pop       = (st == STREAM) && enable && !err && fifo_rd_valid && !pop_guard &&
                     (!out_valid || out_ready);
  assign fifo_read = pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st              <= IDLE;
      pf_cnt          <= '0;
      rst_cnt         <= '0;
      pop_guard       <= 1'b0;
      fifo_rd_enable  <= 1'b0;
      fifo_rst_n      <= 1'b1;
      out_data        <= '0;
      out_valid       <= 1'b0;
      link_active     <= 1'b0;
      overflow_count  <= '0;
      underflow_count <= '0;
    end else begin
      pop_guard <= pop;

      if (active && fifo_overflow && (overflow_count != CNT_MAX))
        overflow_count <= overflow_count + 1'b1;
      if (active && fifo_underflow && (underflow_count != CNT_MAX))
        underflow_count <= underflow_count + 1'b1;

      case (st)
        IDLE: begin
          if (enable) begin
            st             <= PREFILL;
            pf_cnt         <= '0;
            fifo_rd_enable <= 1'b1;
          end
        end

        PREFILL: begin
          if (err) begin
            st             <= RECOVER;
            rst_cnt        <= '0;
            fifo_rst_n     <= 1'b0;
            fifo_rd_enable <= 1'b0;
          end else if (!enable) begin
            st             <= IDLE;
            fifo_rd_enable <= 1'b0;
          end else if (fifo_rd_valid) begin
            if (pf_cnt == PF_LAST) begin
              st          <= STREAM;
              link_active <= 1'b1;
            end else begin
              pf_cnt <= pf_cnt + 1'b1;
            end
          end else begin
            pf_cnt <= '0;
          end
        end

        STREAM: begin
          if (err) begin
            st             <= RECOVER;
            rst_cnt        <= '0;
            fifo_rst_n     <= 1'b0;
            fifo_rd_enable <= 1'b0;
            link_active    <= 1'b0;
            out_valid      <= 1'b0;
          end else if (!enable) begin
            st             <= IDLE;
            fifo_rd_enable <= 1'b0;
            link_active    <= 1'b0;
            out_valid      <= 1'b0;
          end else if (pop) begin
            out_data  <= fifo_rd_data;
            out_valid <= 1'b1;
          end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
          end
        end

        RECOVER: begin
          // RST_CYCLES cycles with the FIFO in reset, then one settle cycle.
          if (rst_cnt == RST_END) begin
            st             <= enable ? PREFILL : IDLE;
            fifo_rd_enable <= enable;
            pf_cnt         <= '0;
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
            if (rst_cnt == RST_LAST)
              fifo_rst_n <= 1'b1;
          end
        end

        default: st <= IDLE;
      endcase
    end
  end

endmodule
